// File: rtl/booth_r4_pp_accumulator.sv
// Iterative accumulator for the 17-term radix-4 Booth partial-product stream of a 32x32 multiply.
// Optional sequence checking (pp_last vs. index, seq_err output) is enabled by BOOTH_ACC_SEQCHK_EN.
module booth_r4_pp_accumulator (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        pp_valid,
  output logic        pp_ready,
  input  logic [33:0] pp_data,
  input  logic        pp_last,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] product
`ifdef BOOTH_ACC_SEQCHK_EN
  ,
  output logic        seq_err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [4:0]  r_idx;
  logic [63:0] r_acc;
  logic        r_pp_ready;
  logic        r_res_valid;

  logic        w_accept;
  logic        w_is_last_idx;
  logic        w_done;
  logic [63:0] w_term;
  logic [63:0] w_acc_base;

  // Weight of partial product idx: digit terms are signed and shifted by 2*idx,
  // the index-16 correction is an unsigned 32-bit value placed at bit 32.
  function automatic logic [63:0] term_f(input logic [4:0] idx, input logic [33:0] d);
    logic [63:0] v;
    if (idx == 5'd16) begin
      v = {d[31:0], 32'd0};
    end else begin
      v = {{30{d[33]}}, d} << {idx[3:0], 1'b0};
    end
    return v;
  endfunction

  assign w_accept      = pp_valid & r_pp_ready;
  assign w_is_last_idx = (r_idx == 5'd16);
  assign w_term        = term_f(r_idx, pp_data);
  assign w_acc_base    = (r_state == S_ACC) ? r_acc : 64'd0;

`ifdef BOOTH_ACC_SEQCHK_EN
  logic r_seq_err;
  logic w_seq_bad;

  assign w_done    = w_is_last_idx | pp_last;
  assign w_seq_bad = pp_last ^ w_is_last_idx;
  assign seq_err   = r_seq_err;

  // Sticky sequence-error flag, cleared only by reset or flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seq_err <= 1'b0;
    end else if (flush) begin
      r_seq_err <= 1'b0;
    end else if (w_accept && w_seq_bad) begin
      r_seq_err <= 1'b1;
    end else begin
      r_seq_err <= r_seq_err;
    end
  end
`else
  logic w_unused_pp_last;

  assign w_done           = w_is_last_idx;
  assign w_unused_pp_last = pp_last;
`endif

  // Control FSM, beat counter and accumulator with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= 5'd0;
      r_acc       <= 64'd0;
      r_pp_ready  <= 1'b1;
      r_res_valid <= 1'b0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_idx       <= 5'd0;
      r_acc       <= 64'd0;
      r_pp_ready  <= 1'b1;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_ACC: begin
          if (w_accept) begin
            r_acc <= w_acc_base + w_term;
            r_idx <= r_idx + 5'd1;
            if (w_done) begin
              r_state     <= S_DONE;
              r_pp_ready  <= 1'b0;
              r_res_valid <= 1'b1;
            end else begin
              r_state <= S_ACC;
            end
          end
        end
        S_DONE: begin
          if (res_ready) begin
            r_state     <= S_IDLE;
            r_idx       <= 5'd0;
            r_pp_ready  <= 1'b1;
            r_res_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_idx       <= 5'd0;
          r_acc       <= 64'd0;
          r_pp_ready  <= 1'b1;
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

  assign pp_ready  = r_pp_ready;
  assign res_valid = r_res_valid;
  assign product   = r_acc;

endmodule

// File: tb/tb_booth_r4_pp_accumulator.sv
// Scoreboard bench for booth_r4_pp_accumulator: expected products are queued at stream start and
// checked by a monitor on each result handshake. Honours BOOTH_ACC_SEQCHK_EN.
module tb_booth_r4_pp_accumulator;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        pp_valid;
  logic        pp_ready;
  logic [33:0] pp_data;
  logic        pp_last;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] product;
`ifdef BOOTH_ACC_SEQCHK_EN
  logic        seq_err;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;
  logic [33:0] v[17];

  booth_r4_pp_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .pp_valid  (pp_valid),
    .pp_ready  (pp_ready),
    .pp_data   (pp_data),
    .pp_last   (pp_last),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .product   (product)
`ifdef BOOTH_ACC_SEQCHK_EN
    ,
    .seq_err   (seq_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Monitor: one comparison per completed result handshake.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %h required no result", product);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("product", product, mon_exp);
      end
    end
  end

  task automatic clr_v();
    for (int i = 0; i < 17; i++) v[i] = 34'd0;
  endtask

  task automatic beat(input logic [33:0] d, input logic last);
    int n;
    n = 0;
    pp_valid = 1'b1;
    pp_data  = d;
    pp_last  = last;
    forever begin
      @(negedge clk);
      if (pp_ready) break;
      n++;
      if (n > 50) begin
        chk("pp_ready_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    pp_valid = 1'b0;
    pp_last  = 1'b0;
  endtask

  task automatic run_stream(input logic [63:0] exp, input int maxgap);
    exp_q.push_back(exp);
    for (int i = 0; i < 17; i++) begin
      if (maxgap > 0) begin
        repeat ($urandom_range(0, maxgap)) begin
          @(posedge clk);
          #1;
        end
      end
      beat(v[i], (i == 16) ? 1'b1 : 1'b0);
      if (i == 15) chk("res_valid_early", {63'd0, res_valid}, 64'd0);
    end
    chk("res_valid_latency", {63'd0, res_valid}, 64'd1);
    chk("pp_ready_done", {63'd0, pp_ready}, 64'd0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    pp_valid  = 1'b0;
    pp_data   = 34'd0;
    pp_last   = 1'b0;
    res_ready = 1'b1;
    #12;
    chk("rst_pp_ready", {63'd0, pp_ready}, 64'd1);
    chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("rst_product", product, 64'd0);
`ifdef BOOTH_ACC_SEQCHK_EN
    chk("rst_seq_err", {63'd0, seq_err}, 64'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 3*5
    clr_v(); v[0] = 34'd3; v[1] = 34'd3;
    run_stream(64'h0000_0000_0000_000F, 0);
    wait_drain();

    // -1*-1: digit -1 times a=-1 gives +1
    clr_v(); v[0] = 34'd1;
    run_stream(64'h0000_0000_0000_0001, 0);
    wait_drain();

    // 1*-1: digit -1 times a=1
    clr_v(); v[0] = 34'h3_FFFF_FFFF;
    run_stream(64'hFFFF_FFFF_FFFF_FFFF, 0);
    wait_drain();

    // unsigned 0xFFFFFFFF^2, correction upper bits must be ignored
    clr_v(); v[0] = 34'h3_0000_0001; v[16] = 34'h3_FFFF_FFFF;
    run_stream(64'hFFFF_FFFE_0000_0001, 0);
    wait_drain();

    // middle and top digit weights
    clr_v(); v[7] = 34'd5; v[15] = 34'h3_FFFF_FFFF;
    run_stream(64'hFFFF_FFFF_C001_4000, 0);
    wait_drain();

    // carry out of bit 63 dropped
    clr_v(); v[15] = 34'h1_0000_0000; v[16] = 34'h0_FFFF_FFFF;
    run_stream(64'h3FFF_FFFF_0000_0000, 0);
    wait_drain();

    // random gaps plus result backpressure
    clr_v(); v[0] = 34'h3_0000_0001; v[16] = 34'h0_FFFF_FFFF;
    res_ready = 1'b0;
    run_stream(64'hFFFF_FFFE_0000_0001, 2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_product", product, 64'hFFFF_FFFE_0000_0001);
      chk("bp_pp_ready", {63'd0, pp_ready}, 64'd0);
      chk("bp_res_valid", {63'd0, res_valid}, 64'd1);
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_pp_ready_after", {63'd0, pp_ready}, 64'd1);
    chk("bp_res_valid_after", {63'd0, res_valid}, 64'd0);
    wait_drain();

    // flush after beat 7, beat presented during flush is discarded
    clr_v(); v[0] = 34'd3; v[1] = 34'd3;
    for (int i = 0; i < 7; i++) beat(v[i], 1'b0);
    pp_valid = 1'b1;
    pp_data  = 34'd1;
    pulse_flush();
    pp_valid = 1'b0;
    chk("flush_product", product, 64'd0);
    chk("flush_pp_ready", {63'd0, pp_ready}, 64'd1);
    chk("flush_res_valid", {63'd0, res_valid}, 64'd0);
    run_stream(64'h0000_0000_0000_000F, 0);
    wait_drain();

    // asynchronous reset while a result is waiting
    res_ready = 1'b0;
    for (int i = 0; i < 17; i++) beat(v[i], (i == 16) ? 1'b1 : 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("arst_pp_ready", {63'd0, pp_ready}, 64'd1);
    chk("arst_product", product, 64'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    res_ready = 1'b1;
    @(posedge clk);
    #1;

    // pp_last on beat 10
    clr_v(); v[0] = 34'd3; v[1] = 34'd3; v[12] = 34'd1;
`ifdef BOOTH_ACC_SEQCHK_EN
    exp_q.push_back(64'h0000_0000_0000_000F);
    for (int i = 0; i < 10; i++) beat(v[i], (i == 9) ? 1'b1 : 1'b0);
    chk("early_done", {63'd0, res_valid}, 64'd1);
    chk("early_seq_err", {63'd0, seq_err}, 64'd1);
    wait_drain();
    pulse_flush();
    chk("flush_seq_err", {63'd0, seq_err}, 64'd0);

    // no pp_last on beat 17
    clr_v(); v[0] = 34'd3; v[1] = 34'd3;
    exp_q.push_back(64'h0000_0000_0000_000F);
    for (int i = 0; i < 17; i++) beat(v[i], 1'b0);
    chk("nolast_done", {63'd0, res_valid}, 64'd1);
    chk("nolast_seq_err", {63'd0, seq_err}, 64'd1);
    wait_drain();
    pulse_flush();
`else
    exp_q.push_back(64'h0000_0000_0100_000F);
    for (int i = 0; i < 17; i++) begin
      beat(v[i], (i == 9) ? 1'b1 : 1'b0);
      if (i == 9) chk("last_ignored", {63'd0, res_valid}, 64'd0);
    end
    chk("last_ignored_done", {63'd0, res_valid}, 64'd1);
    wait_drain();
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
